// File: rtl/boe_pkg.sv
// Shared constants, FSM state encoding and frame-length decode for the BOE result path.
// No logic of its own.
// Used by the collector RTL and by the producer-side drivers.
package boe_pkg;

  localparam int DW   = 8;   // sample width
  localparam int RW   = 11;  // result word width, holds the sum of 8 samples
  localparam int MAXN = 8;   // sample buffer depth

  typedef enum logic [2:0] {
    IDLE,
    GET_SUM,
    GET_MAX,
    GET_DATA,
    RECON,
    EMIT
  } state_t;

  // 3-bit frame-length field: 0 means 8 samples, 1..7 are literal
  function automatic logic [3:0] num_to_len(input logic [2:0] num);
    return (num == 3'd0) ? 4'd8 : {1'b0, num};
  endfunction

endpackage

// File: rtl/boe_collector_if.sv
// Stream bundle: result words into the collector and recovered samples out of it.
// Wires only, no latency.
// The out_valid/out_ready pair carries the backpressure; the result side cannot be stalled.
interface boe_collector_if;
  import boe_pkg::*;

  logic          res_valid;
  logic [RW-1:0] result;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  // producer / downstream consumer side
  modport master (
    output res_valid, result, out_ready,
    input  data_out, out_valid, out_last
  );

  // collector side
  modport slave (
    input  res_valid, result, out_ready,
    output data_out, out_valid, out_last
  );

endinterface

// File: rtl/boe_sample_buf.sv
// MAXN x DW register file: one synchronous write port, one combinational read port.
// Write visible on the read port the cycle after the write edge.
// No flow control; the owner decides when to write.
module boe_sample_buf
  import boe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [2:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [MAXN];

  // storage: cleared on reset, single write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAXN; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // combinational read
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/boe_collector.sv
// Recovers a BOE frame's samples (SUM, MAX, samples N-1..1) and rebuilds sample 0 as SUM minus the rest.
// First out_valid 2 cycles after the last stream word, then 1 sample/cycle.
// Output stalls on out_ready=0; result stream is never stalled. Option: BOE_COLLECT_STATS_EN adds counters.
module boe_collector
  import boe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  data_num,
  boe_collector_if.slave bus,
  output logic        err_max,
  output logic        err_range,
  output logic        busy
`ifdef BOE_COLLECT_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  state_t        state, state_nxt;
  logic [3:0]    len;
  logic [2:0]    cnt;
  logic [2:0]    idx;
  logic [RW-1:0] acc;
  logic [RW-1:0] sum_w;
  logic [RW-1:0] max_w;
  logic [DW-1:0] runmax;

  logic [3:0]    start_len;
  logic [3:0]    start_len_m1;
  logic [3:0]    len_m1;
  logic          is_last;
  logic          xfer;
  logic [RW:0]   d0;
  logic [DW-1:0] d0_byte;
  logic          d0_bad;
  logic [DW-1:0] final_max;
  logic [DW-1:0] res_byte;
  logic [DW-1:0] new_runmax;

  logic          buf_we;
  logic [2:0]    buf_waddr;
  logic [DW-1:0] buf_wdata;
  logic [DW-1:0] buf_rdata;

  boe_sample_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (idx),
    .rdata (buf_rdata)
  );

  // frame arithmetic: sample 0 reconstruction, range and max checks, length decode
  always_comb begin
    start_len    = num_to_len(data_num);
    start_len_m1 = start_len - 4'd1;
    len_m1       = len - 4'd1;
    is_last      = ({1'b0, idx} == len_m1);
    d0           = {1'b0, sum_w} - {1'b0, acc};
    d0_byte      = d0[DW-1:0];
    // negative (borrow into top bit) or wider than a sample
    d0_bad       = d0[RW] | (|d0[RW-1:DW]);
    final_max    = (d0_byte > runmax) ? d0_byte : runmax;
    res_byte     = bus.result[DW-1:0];
    new_runmax   = (res_byte > runmax) ? res_byte : runmax;
  end

  // next state, handshake outputs and buffer write control
  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    bus.out_valid = (state == EMIT);
    bus.out_last  = (state == EMIT) && is_last;
    bus.data_out  = (state == EMIT) ? buf_rdata : '0;
    xfer          = bus.out_valid && bus.out_ready;
    buf_we        = 1'b0;
    buf_waddr     = cnt;
    buf_wdata     = res_byte;
    case (state)
      IDLE: begin
        if (start) state_nxt = GET_SUM;
      end
      GET_SUM: begin
        if (bus.res_valid) state_nxt = GET_MAX;
      end
      GET_MAX: begin
        if (bus.res_valid) state_nxt = (len == 4'd1) ? RECON : GET_DATA;
      end
      GET_DATA: begin
        if (bus.res_valid) begin
          buf_we = 1'b1;
          if (cnt == 3'd1) state_nxt = RECON;
        end
      end
      RECON: begin
        buf_we    = 1'b1;
        buf_waddr = 3'd0;
        buf_wdata = d0_byte;
        state_nxt = EMIT;
      end
      EMIT: begin
        if (xfer && is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // frame datapath: length, counters, accumulators and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= 4'd0;
      cnt       <= 3'd0;
      idx       <= 3'd0;
      acc       <= '0;
      sum_w     <= '0;
      max_w     <= '0;
      runmax    <= '0;
      err_max   <= 1'b0;
      err_range <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len       <= start_len;
            cnt       <= start_len_m1[2:0];
            acc       <= '0;
            runmax    <= '0;
            err_max   <= 1'b0;
            err_range <= 1'b0;
          end
        end
        GET_SUM: begin
          if (bus.res_valid) sum_w <= bus.result;
        end
        GET_MAX: begin
          if (bus.res_valid) max_w <= bus.result;
        end
        GET_DATA: begin
          if (bus.res_valid) begin
            acc    <= acc + bus.result;
            runmax <= new_runmax;
            if (|bus.result[RW-1:DW]) err_range <= 1'b1;
            if (cnt != 3'd1) cnt <= cnt - 3'd1;
          end
        end
        RECON: begin
          if (d0_bad) err_range <= 1'b1;
          if (max_w != {{(RW-DW){1'b0}}, final_max}) err_max <= 1'b1;
          idx <= 3'd0;
        end
        EMIT: begin
          if (xfer) idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef BOE_COLLECT_STATS_EN
  // per-frame statistics, counted on the transfer of the last sample
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else if (xfer && bus.out_last) begin
      frame_cnt <= frame_cnt + 16'd1;
      if (err_max || err_range) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_boe_collector.sv
// Directed bench for boe_collector with a scoreboard of expected output samples.
module tb_boe_collector;
  import boe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] data_num;
  logic       err_max;
  logic       err_range;
  logic       busy;
`ifdef BOE_COLLECT_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  boe_collector_if bus();

  boe_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_num  (data_num),
    .bus       (bus),
    .err_max   (err_max),
    .err_range (err_range),
    .busy      (busy)
`ifdef BOE_COLLECT_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [8:0] sb[$];   // {last, data}
  logic       hold_vld = 1'b0;
  logic [8:0] hold_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic last);
    logic [31:0] v;
    v = d;
    sb.push_back({last, v[7:0]});
  endtask

  task automatic send(input int w);
    logic [31:0] v;
    v = w;
    bus.res_valid = 1'b1;
    bus.result    = v[10:0];
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [2:0] num);
    start    = 1'b1;
    data_num = num;
    tick();
    start    = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic em, input logic er);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, sb.size(), 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_max"}, err_max, em);
    check({tag, "_err_range"}, err_range, er);
  endtask

  // output monitor: pops the scoreboard on each transfer, checks hold during stalls
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (rst) begin
      hold_vld = 1'b0;
    end else if (bus.out_valid) begin
      if (hold_vld) check("stall_hold", {bus.out_last, bus.data_out}, hold_val);
      if (bus.out_ready) begin
        hold_vld = 1'b0;
        xfers++;
        if (sb.size() == 0) begin
          check("out_without_expect", bus.out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("sample", {bus.out_last, bus.data_out}, e);
        end
      end else begin
        hold_vld = 1'b1;
        hold_val = {bus.out_last, bus.data_out};
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int x0;
    rst           = 1'b1;
    start         = 1'b0;
    data_num      = 3'd0;
    bus.res_valid = 1'b0;
    bus.result    = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_data_out", bus.data_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_err_max", err_max, 0);
    check("rst_err_range", err_range, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // N=3, start coincides with a stray result word that must be ignored
    push(10, 0); push(20, 0); push(30, 1);
    start         = 1'b1;
    data_num      = 3'd3;
    bus.res_valid = 1'b1;
    bus.result    = 11'd999;
    tick();
    start         = 1'b0;
    bus.res_valid = 1'b0;
    send(60); send(30); send(30); send(20);
    finish_frame("n3", 0, 0);

    // N=8 with latency probe on the final word
    for (int i = 1; i <= 8; i++) push(i, i == 8);
    start_frame(3'd0);
    send(36); send(8); send(8); send(7); send(6); send(5); send(4); send(3);
    send(2);
    check("n8_recon_gap", bus.out_valid, 0);
    tick();
    check("n8_first_valid", bus.out_valid, 1);
    finish_frame("n8", 0, 0);

    // N=1
    push(5, 1);
    start_frame(3'd1);
    send(5); send(5);
    finish_frame("n1", 0, 0);

    // N=2 with an idle gap in the stream
    push(10, 0); push(40, 1);
    start_frame(3'd2);
    send(50);
    tick();
    send(40); send(40);
    finish_frame("n2", 0, 0);

    // wrong MAX word
    push(10, 0); push(20, 0); push(30, 1);
    start_frame(3'd3);
    send(60); send(25); send(30); send(20);
    finish_frame("badmax", 1, 0);

    // sum below received samples: d0=-10 -> 246 stored, also beats MAX=20
    push(246, 0); push(20, 1);
    start_frame(3'd2);
    send(10); send(20); send(20);
    finish_frame("neg_d0", 1, 1);

    // backpressure, start pulses during EMIT must be ignored
    push(1, 0); push(2, 0); push(3, 0); push(4, 1);
    start_frame(3'd4);
    check("errs_clear_max", err_max, 0);
    check("errs_clear_range", err_range, 0);
    send(10); send(4); send(4); send(3); send(2);
    x0 = xfers;
    for (int i = 0; i < 40 && busy; i++) begin
      bus.out_ready = (i % 4 == 0) || (i % 4 == 3);
      start         = (i == 2) || (i == 5);
      data_num      = 3'd1;
      tick();
      start         = 1'b0;
    end
    bus.out_ready = 1'b1;
    check("bp_xfers", xfers - x0, 4);
    tick();
    tick();
    check("bp_start_ignored", busy, 0);
    check("bp_drain", sb.size(), 0);

    // reset in GET_DATA abandons the frame, then a clean N=2 frame
    start_frame(3'd3);
    send(60); send(30); send(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", bus.out_valid, 0);
    tick(); tick(); tick();
    push(10, 0); push(20, 1);
    start_frame(3'd2);
    send(30); send(20); send(20);
    finish_frame("post_rst", 0, 0);
`ifdef BOE_COLLECT_STATS_EN
    check("frame_cnt", frame_cnt, 1);
    check("err_cnt", err_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boe_collector.md
Name: boe_collector

Overview:
- Receive-side counterpart of the BOE frame producer: consumes the 11-bit result stream BOE emits per frame and recovers the original 8-bit input samples in arrival order.
- Stream per frame: SUM word, MAX word, then samples N-1 down to 1. Sample 0 is never sent; it is reconstructed as SUM minus the received samples.
- Cross-checks MAX and range, then replays samples on a valid/ready output port for downstream consumers and the verification scoreboard.

Parameters:
- DW, 8, sample width
- RW, 11, result word width (DW+3, holds the sum of 8 samples)
- MAXN, 8, sample buffer depth (fixed by the 3-bit num encoding)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame strobe; samples num; honoured only in IDLE
- data_num  in  3  frame length N; 0 encodes N=8, 1..7 literal
- res_valid  in  1  result word present this cycle
- result  in  RW  result stream word
- data_out  out  DW  recovered sample
- out_valid  out  1  data_out valid
- out_ready  in  1  downstream accept
- out_last  out  1  marks sample N-1 of the frame
- err_max  out  1  sticky per frame: MAX word mismatch
- err_range  out  1  sticky per frame: a sample or reconstructed sample does not fit in DW bits
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; data_out=0, out_valid=0, out_last=0, err_max=0, err_range=0, busy=0; buffer, accumulators and counters cleared. Reset mid-frame abandons the frame; no partial output.
- Reset outputs per frame: err_* clear on an accepted start; they hold from RECON until the next start.
- FSM states: IDLE, GET_SUM, GET_MAX, GET_DATA, RECON, EMIT.
- IDLE:
  - start=1 -> latch N, cnt=N-1, acc=0, runmax=0; go to GET_SUM.
  - res_valid is ignored in IDLE.
- GET_SUM: on res_valid, latch sum=result; go to GET_MAX.
- GET_MAX: on res_valid, latch maxw=result.
  - If N=1 -> RECON; else -> GET_DATA.
- GET_DATA: on res_valid:
  - buf[cnt] = result[DW-1:0]; acc += result; runmax = max(runmax, result[DW-1:0]).
  - result[RW-1:DW] != 0 -> err_range=1.
  - cnt==1 -> RECON; else cnt -= 1.
- Cycles without res_valid stall the current state; there is no timeout.
- RECON (exactly 1 cycle):
  - d0 = sum - acc, computed in RW+1 bits.
  - If negative or > 2^DW-1 -> err_range=1; buf[0] = d0[DW-1:0].
  - finalmax = max(runmax, buf[0]); if maxw != finalmax (full RW compare) -> err_max=1.
  - Set idx=0; go to EMIT.
- EMIT:
  - out_valid=1, data_out=buf[idx], out_last=(idx==N-1).
  - Handshake: transfer on out_valid && out_ready; idx += 1. Transfer with out_last -> IDLE.
  - data_out and out_last stay stable while out_valid=1 and out_ready=0.
  - res_valid and start are ignored in EMIT.
- Latency: first out_valid appears 2 cycles after the final stream word (RECON, then EMIT registered). Throughput is 1 sample/cycle with out_ready held high.
- Boundaries:
  - start while busy: ignored.
  - start and res_valid in the same IDLE cycle: only start takes effect.
  - N=8 fills buf[7..1].
  - sum=0 with all samples 0 is legal.

Optional Feature:
- BOE_COLLECT_STATS_EN defined:
  - Adds outputs frame_cnt[15:0] and err_cnt[15:0], both 0 on reset.
  - frame_cnt increments on each out_last transfer.
  - err_cnt increments once per frame if err_max|err_range is set at that transfer.
  - Both counters wrap at 2^16.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package boe_pkg:
  - DW, RW, MAXN constants
  - state enum (IDLE..EMIT)
  - function num_to_len (3-bit -> 1..8), also reused by the producer-side testbench driver
- One natural sub-module: boe_sample_buf, an 8 x DW register file with one write port indexed by cnt and one combinational read port indexed by idx. The FSM and arithmetic remain in boe_collector.

Test Plan:
- N=3, stream 60,30,30,20 -> outputs 10,20,30, out_last on 30, err_max=0, err_range=0.
- data_num=0 (N=8), samples 1..8, stream 36,8,8,7,6,5,4,3,2 -> outputs 1..8 in order, first out_valid 2 cycles after the word 2, no errors.
- N=1, stream 5,5 -> single output 5 with out_last=1; N=2, stream 50,40,40 -> outputs 10,40.
- N=3, stream 60,25,30,20 -> outputs 10,20,30, err_max=1; N=2, stream 10,20,20 -> d0=-10, err_range=1.
- Backpressure: N=4, out_ready toggled 1,0,0,1,... -> data_out held stable while stalled, 4 transfers total; start pulses during EMIT ignored.
- Reset asserted in GET_DATA, then a clean N=2 frame -> no output from the aborted frame, new frame correct; with BOE_COLLECT_STATS_EN, frame_cnt=1 and err_cnt=0.
